// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage (optional 2-entry skid, flush kill with saturating discard count); ports clk_in, rst_in (sync active-low), rdy_in freeze, flush_in, up_valid_in/up_data_in/up_ready_out, dn_valid_out/dn_data_out/dn_ready_in, occupancy_out, flushed_cnt_out
module pipe_stage_reg #(
  parameter int WIDTH = 160,
  parameter int SKID = 1,
  parameter int CLEAR_ON_EMPTY = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             up_valid_in,
  input  logic [WIDTH-1:0] up_data_in,
  output logic             up_ready_out,
  output logic             dn_valid_out,
  output logic [WIDTH-1:0] dn_data_out,
  input  logic             dn_ready_in,
  output logic [1:0]       occupancy_out,
  output logic [7:0]       flushed_cnt_out
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE = 2'd1;
  localparam logic [1:0] TWO = 2'd2;
  logic [1:0] state_q, state_d, disc;
  logic [WIDTH-1:0] main_q, skid_q, main_d, skid_d, main_e, skid_e;
  logic [7:0] cnt_q;
  logic [8:0] cnt_sum;
  logic dn_valid_q, accept, pop;
  assign dn_valid_q = state_q != EMPTY;
  assign up_ready_out = rdy_in & ((SKID != 0) ? (state_q != TWO) : (!dn_valid_q | dn_ready_in));
  assign dn_valid_out = dn_valid_q & rdy_in;
  assign accept = up_valid_in & up_ready_out & !flush_in;
  assign pop = dn_valid_out & dn_ready_in;
  assign state_d = flush_in ? EMPTY : state_q + {1'b0, accept} - {1'b0, pop};
  assign main_e = (CLEAR_ON_EMPTY != 0) ? '0 : main_q;
  assign skid_e = (CLEAR_ON_EMPTY != 0) ? '0 : skid_q;
  assign main_d = (state_d == EMPTY) ? main_e :
                  (state_q == TWO && pop) ? skid_q :
                  (accept && (state_q == EMPTY || pop)) ? up_data_in : main_q;
  assign skid_d = (state_d != TWO) ? skid_e : (state_q == ONE) ? up_data_in : skid_q;
  assign disc = state_q - {1'b0, pop};
  assign cnt_sum = {1'b0, cnt_q} + {7'd0, disc};
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      cnt_q <= '0;
    end else if (rdy_in) begin
      state_q <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
      if (flush_in) cnt_q <= cnt_sum[8] ? 8'hff : cnt_sum[7:0];
    end
  end
  assign dn_data_out = main_q;
  assign occupancy_out = state_q;
  assign flushed_cnt_out = cnt_q;
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 160, meaning payload bits per entry (legal range 1..512).
REQ-002 SHALL have parameter SKID, default 1, meaning 1 = two-entry skid stage with registered up_ready_out, 0 = single-entry stage.
REQ-003 SHALL have parameter CLEAR_ON_EMPTY, default 1, meaning an empty stage drives an all-zero payload (NOP bubble), 0 = payload holds its last value.
REQ-004 SHALL have port clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_in, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port rdy_in, input, 1 bit: global enable; 0 freezes the block.
REQ-007 SHALL have port flush_in, input, 1 bit: discard all held entries (branch/jump kill).
REQ-008 SHALL have port up_valid_in, input, 1 bit: upstream entry valid.
REQ-009 SHALL have port up_data_in, input, WIDTH bits: upstream payload.
REQ-010 SHALL have port up_ready_out, output, 1 bit: stage can accept an entry this cycle.
REQ-011 SHALL have port dn_valid_out, output, 1 bit: head entry valid.
REQ-012 SHALL have port dn_data_out, output, WIDTH bits: head entry payload.
REQ-013 SHALL have port dn_ready_in, input, 1 bit: downstream accepts head entry.
REQ-014 SHALL have port occupancy_out, output, 2 bits: entries held (0..2; 0..1 when SKID=0).
REQ-015 SHALL have port flushed_cnt_out, output, 8 bits: saturating count of valid entries discarded by flush.

Function
REQ-016 SHALL define accept = up_valid_in & up_ready_out & !flush_in, and pop = dn_valid_out & dn_ready_in.
REQ-017 SHALL force up_ready_out=0 and dn_valid_out=0 while rdy_in=0, with no state, data or counter change.
REQ-018 SHALL, for SKID=1, drive up_ready_out from registered state only: 1 in EMPTY or ONE, 0 in TWO. It SHALL have no combinational path from dn_ready_in.
REQ-019 SHALL, for SKID=0, drive up_ready_out = !dn_valid_q | dn_ready_in, gated by rdy_in; only states EMPTY/ONE exist.
REQ-020 SHALL hold head entry in main register and overflow in skid register. dn_data_out = main; dn_valid_out = (state!=EMPTY) & rdy_in.
REQ-021 SHALL transition, from EMPTY: accept -> ONE, main<=up_data_in.
REQ-022 SHALL transition, from ONE:
- accept&pop -> ONE, main<=up_data_in
- accept&!pop -> TWO, skid<=up_data_in
- pop&!accept -> EMPTY
- otherwise hold
REQ-023 SHALL transition, from TWO: pop -> ONE, main<=skid; otherwise hold; accept impossible.
REQ-024 SHALL preserve FIFO order; no entry is duplicated or lost except by flush.
REQ-025 SHALL give zero-bubble throughput: one entry per cycle sustained while up_valid_in=dn_ready_in=1; latency up_data_in -> dn_data_out is exactly 1 cycle when EMPTY.
REQ-026 SHALL, on flush_in=1 with rdy_in=1, go to EMPTY next cycle regardless of accept/pop. A pop completing in the flush cycle is still counted as delivered.
REQ-027 SHALL, on flush, add the number of entries discarded to flushed_cnt_out. Discarded = occupancy minus 1 if pop occurred that cycle. The count saturates at 255, no wrap.
REQ-028 SHALL, when CLEAR_ON_EMPTY=1, load main and skid with 0 whenever they become empty (pop-to-EMPTY, flush). dn_data_out SHALL be 0 whenever occupancy is 0.
REQ-029 SHALL update occupancy_out with the state register (EMPTY=0, ONE=1, TWO=2).

Reset
REQ-030 SHALL, when rst_in=0 at a clock edge, set state EMPTY, main=0, skid=0, flushed_cnt_out=0. Reset takes priority over rdy_in and flush_in.
REQ-031 SHALL, during and right after reset, present outputs dn_valid_out=0, dn_data_out=0, occupancy_out=0, and up_ready_out=1 (if rdy_in=1).
REQ-032 SHALL, on reset asserted mid-operation (state TWO), discard both entries without incrementing flushed_cnt_out.

Verification
REQ-033 SHALL cover streaming: SKID=1, up_valid_in=1 with data 1,2,3,4, dn_ready_in=1 -> dn_data_out 1,2,3,4 on consecutive cycles starting 1 cycle after first accept; occupancy_out stays 1.
REQ-034 SHALL cover backpressure: push A,B with dn_ready_in=0 -> occupancy_out=2, up_ready_out=0; then raise dn_ready_in -> A, then B, then dn_valid_out=0, dn_data_out=0.
REQ-035 SHALL cover flush: hold A,B (TWO), flush_in=1 with dn_ready_in=0 -> next cycle occupancy_out=0 and flushed_cnt_out=2; then repeat with dn_ready_in=1 -> A delivered, flushed_cnt_out +1.
REQ-036 SHALL cover freeze: ONE holding 0x5A, rdy_in=0 for 3 cycles with dn_ready_in=1 and up_valid_in=1 -> up_ready_out=0, dn_valid_out=0, occupancy_out stays 1; after rdy_in=1, 0x5A pops.
REQ-037 SHALL cover saturation: 300 single-entry flushes -> flushed_cnt_out=255.
REQ-038 SHALL cover SKID=0: dn_ready_in=0 while ONE -> up_ready_out=0; dn_ready_in=1 -> same-cycle accept and pop, occupancy_out stays 1.
